// File: rtl/dbus_burst_ram_if.sv
// 16-bit dbus Avalon-MM-style bus: an initiator drives commands, a responder
// answers with waitrequest and registered read beats.
interface dbus_if #(
   parameter int BURST_WIDTH = 7
) ();
   logic [24:0]            dbus_address;
   logic [15:0]            dbus_writedata;
   logic [1:0]             dbus_byteenable;
   logic [BURST_WIDTH-1:0] dbus_burstcount;
   logic                   dbus_read;
   logic                   dbus_write;
   logic [15:0]            dbus_readdata;
   logic                   dbus_waitrequest;
   logic                   dbus_readdatavalid;

   modport master (
      output dbus_address, dbus_writedata, dbus_byteenable, dbus_burstcount,
      output dbus_read, dbus_write,
      input  dbus_readdata, dbus_waitrequest, dbus_readdatavalid
   );

   modport slave (
      input  dbus_address, dbus_writedata, dbus_byteenable, dbus_burstcount,
      input  dbus_read, dbus_write,
      output dbus_readdata, dbus_waitrequest, dbus_readdatavalid
   );
endinterface

// File: rtl/dbus_burst_ram.sv
// Burst-capable dbus responder over a synchronous word array; first read beat is
// valid the cycle after acceptance, writes are zero-wait, waitrequest holds off during read bursts.
module dbus_burst_ram #(
   parameter int DEPTH_LOG2  = 8,
   parameter int BURST_WIDTH = 7
) (
   input  logic   clk,
   input  logic   rst,
   dbus_if.slave  dbus
);
   typedef enum logic [1:0] {S_IDLE, S_WR_BURST, S_RD_BURST} state_e;

   state_e                 state_q, state_d;
   logic [BURST_WIDTH-1:0] cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]  addr_q, addr_d;
   logic [15:0]            rdata_q;
   logic                   rvld_q, rvld_d;

   logic [15:0]            mem [0:(1<<DEPTH_LOG2)-1];

   logic [DEPTH_LOG2-1:0]  bus_idx;
   logic [BURST_WIDTH-1:0] bc_eff;
   logic                   we;
   logic                   re;
   logic [DEPTH_LOG2-1:0]  waddr;
   logic [DEPTH_LOG2-1:0]  raddr;
   logic                   waitreq;
   logic                   unused_addr_bits;

   assign bus_idx = dbus.dbus_address[DEPTH_LOG2:1];
   assign bc_eff  = (dbus.dbus_burstcount == '0) ? BURST_WIDTH'(1) : dbus.dbus_burstcount;
   assign unused_addr_bits = ^{dbus.dbus_address[24:DEPTH_LOG2+1], dbus.dbus_address[0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      rvld_d  = 1'b0;
      we      = 1'b0;
      re      = 1'b0;
      waddr   = addr_q;
      raddr   = addr_q;
      waitreq = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dbus.dbus_read && dbus.dbus_write) begin
               waitreq = 1'b1;
            end else if (dbus.dbus_write) begin
               we      = 1'b1;
               waddr   = bus_idx;
               addr_d  = bus_idx + DEPTH_LOG2'(1);
               cnt_d   = bc_eff - BURST_WIDTH'(1);
               if (bc_eff != BURST_WIDTH'(1)) state_d = S_WR_BURST;
            end else if (dbus.dbus_read) begin
               // Beat 1 is read straight from the bus address so it lands one cycle after acceptance.
               re      = 1'b1;
               rvld_d  = 1'b1;
               raddr   = bus_idx;
               addr_d  = bus_idx + DEPTH_LOG2'(1);
               cnt_d   = bc_eff - BURST_WIDTH'(1);
               state_d = S_RD_BURST;
            end
         end
         S_WR_BURST: begin
            if (dbus.dbus_write) begin
               we     = 1'b1;
               addr_d = addr_q + DEPTH_LOG2'(1);
               cnt_d  = cnt_q - BURST_WIDTH'(1);
               if (cnt_q == BURST_WIDTH'(1)) state_d = S_IDLE;
            end
         end
         S_RD_BURST: begin
            // Stay here through the last beat so waitrequest covers it.
            waitreq = 1'b1;
            if (cnt_q != '0) begin
               re     = 1'b1;
               rvld_d = 1'b1;
               addr_d = addr_q + DEPTH_LOG2'(1);
               cnt_d  = cnt_q - BURST_WIDTH'(1);
            end else begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (rst) begin
         waitreq = 1'b1;
         we      = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         rdata_q <= 16'h0000;
         rvld_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         rvld_q  <= rvld_d;
         if (re) rdata_q <= mem[raddr];
      end
   end

   always_ff @(posedge clk) begin
      if (we) begin
         if (dbus.dbus_byteenable[1]) mem[waddr][15:8] <= dbus.dbus_writedata[15:8];
         if (dbus.dbus_byteenable[0]) mem[waddr][7:0]  <= dbus.dbus_writedata[7:0];
      end
   end

   assign dbus.dbus_readdata      = rdata_q;
   assign dbus.dbus_readdatavalid = rvld_q;
   assign dbus.dbus_waitrequest   = waitreq;
endmodule
